// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter for a 1-cycle-latency byte-write memory; KV32_MEM_ARB_RR_EN selects round-robin over fixed data priority
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_valid,
  output logic                    i_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic [ADDR_WIDTH-1:0]   d_req_addr,
  input  logic [DATA_WIDTH/8-1:0] d_req_we,
  input  logic [DATA_WIDTH-1:0]   d_req_wdata,
  output logic                    i_rsp_valid,
  output logic [DATA_WIDTH-1:0]   i_rsp_rdata,
  output logic                    d_rsp_valid,
  output logic [DATA_WIDTH-1:0]   d_rsp_rdata,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;
  owner_t owner;
  logic gnt_i, gnt_d;
`ifdef KV32_MEM_ARB_RR_EN
  logic pref_i;
  always_ff @(posedge clk)
    if (rst) pref_i <= 1'b0;
    else if (gnt_i || gnt_d) pref_i <= gnt_d;
  assign gnt_i = !rst && i_req_valid && (!d_req_valid || pref_i);
`else
  assign gnt_i = !rst && i_req_valid && !d_req_valid;
`endif
  assign gnt_d = !rst && d_req_valid && !gnt_i;
  assign i_req_ready = gnt_i;
  assign d_req_ready = gnt_d;
  assign mem_en = gnt_i || gnt_d;
  assign mem_we = gnt_d ? d_req_we : '0;
  assign mem_addr = gnt_d ? d_req_addr : i_req_addr;
  assign mem_din = gnt_d ? d_req_wdata : '0;
  always_ff @(posedge clk)
    if (rst) owner <= OWN_NONE;
    else owner <= gnt_d ? OWN_D : gnt_i ? OWN_I : OWN_NONE;
  assign i_rsp_valid = !rst && owner == OWN_I;
  assign d_rsp_valid = !rst && owner == OWN_D;
  assign i_rsp_rdata = i_rsp_valid ? mem_dout : '0;
  assign d_rsp_rdata = d_rsp_valid ? mem_dout : '0;
endmodule
